// File: rtl/nanov_serial_sequencer_pkg.sv
// Shared constants for the nanoV bit-serial sequencer: state codes, opcodes, counter width.
package nanoV_seq_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_CMP   = 2'd2;
    localparam logic [1:0] ST_SLTWR = 2'd3;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;

endpackage

// File: rtl/nanov_serial_sequencer_decode.sv
// Pure combinational RV32E decode of the subset the serial datapath supports.
module nanoV_instr_decode
    import nanoV_seq_pkg::*;
(
    input  logic [31:0] instr,
    output logic        legal,
    output logic        is_slt,
    output logic        is_store,
    output logic        wr_rd,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  alu_op,
    output logic [31:0] imm
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       is_op;
    logic       is_opimm;
    logic       arith_ok;

    // Field extraction and legality; shifts are not supported by this datapath.
    always_comb begin
        opc      = instr[6:0];
        f3       = instr[14:12];
        is_op    = (opc == OPC_OP);
        is_opimm = (opc == OPC_OPIMM);
        is_store = (opc == OPC_STORE);
        arith_ok = (is_op || is_opimm) && (f3 != F3_SLL) && (f3 != F3_SR);
        legal    = (arith_ok || (is_store && (f3 == F3_SW)))
                   && !instr[19]
                   && !((is_op || is_store) && instr[24])
                   && !((is_op || is_opimm) && instr[11]);
        is_slt   = (is_op || is_opimm) && ((f3 == F3_SLT) || (f3 == F3_SLTU));
        rs1      = instr[18:15];
        rs2      = instr[23:20];
        rd       = instr[10:7];
        wr_rd    = !is_store && (instr[10:7] != 4'd0);
        alu_op   = {instr[30] & instr[5], f3};
        imm      = {{20{instr[31]}}, instr[31:20]};
    end

endmodule

// File: rtl/nanov_serial_sequencer.sv
// Steps the bit-serial nanoV ALU/register file through one instruction at a time.
module nanov_serial_sequencer
    import nanoV_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [CNT_W-1:0] counter,
    output logic [3:0]       rs1,
    output logic [3:0]       rs2,
    output logic [3:0]       rd,
    output logic             reg_pause,
    output logic             reg_wr_en,
    output logic             rd_src,
    output logic             slt_bit,
    output logic [3:0]       alu_op,
    output logic             alu_b_sel_rs2,
    output logic             alu_imm_bit,
    output logic             alu_cy_in,
    input  logic             alu_cy_out,
    input  logic             alu_lts,
    output logic             store_bit_en,
    output logic             done,
    output logic             illegal
);

    logic             dec_legal, dec_is_slt, dec_is_store, dec_wr_rd;
    logic [3:0]       dec_rs1, dec_rs2, dec_rd, dec_alu_op;
    logic [31:0]      dec_imm;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic             slt_q, slt_d;
    logic             cy_q, cy_d;
    logic             accept;

    logic [3:0]       rs1_q, rs2_q, rd_q, alu_op_q;
    logic             is_store_q, wr_rd_q, b_sel_q;
    logic [31:0]      imm_q;

    nanoV_instr_decode u_decode (
        .instr    (instr),
        .legal    (dec_legal),
        .is_slt   (dec_is_slt),
        .is_store (dec_is_store),
        .wr_rd    (dec_wr_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .alu_op   (dec_alu_op),
        .imm      (dec_imm)
    );

    assign instr_ready = (state_q == ST_IDLE) && rstn;
    assign accept      = instr_valid && instr_ready;

    // Next-state, bit counter, retire/reject pulses, SLT result and carry chain.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        slt_d     = slt_q;
        cy_d      = (state_q == ST_IDLE) ? cy_q : alu_cy_out;
        case (state_q)
            ST_IDLE: begin
                counter_d = '0;
                if (accept) begin
                    if (dec_legal) state_d = dec_is_slt ? ST_CMP : ST_EXEC;
                    else           illegal_d = 1'b1;
                end
            end
            ST_EXEC, ST_SLTWR: begin
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_CMP: begin
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_LAST) begin
                    slt_d   = alu_op_q[0] ? ~alu_cy_out : alu_lts;
                    state_d = ST_SLTWR;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = '0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            slt_q     <= 1'b0;
            cy_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            slt_q     <= slt_d;
            cy_q      <= cy_d;
        end
    end

    // Instruction fields held for the whole serial pass.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_op_q   <= '0;
            is_store_q <= 1'b0;
            wr_rd_q    <= 1'b0;
            b_sel_q    <= 1'b0;
            imm_q      <= '0;
        end else if (accept && dec_legal) begin
            rs1_q      <= dec_rs1;
            rs2_q      <= dec_rs2;
            rd_q       <= dec_rd;
            alu_op_q   <= dec_alu_op;
            is_store_q <= dec_is_store;
            wr_rd_q    <= dec_wr_rd;
            b_sel_q    <= instr[5];
            imm_q      <= dec_imm;
        end
    end

    assign counter       = counter_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign rd            = rd_q;
    assign alu_op        = alu_op_q;
    assign alu_b_sel_rs2 = b_sel_q;
    assign alu_imm_bit   = imm_q[counter_q];
    assign reg_pause     = (state_q == ST_IDLE);
    assign reg_wr_en     = ((state_q == ST_EXEC) || (state_q == ST_SLTWR)) && wr_rd_q;
    assign store_bit_en  = (state_q == ST_EXEC) && is_store_q;
    assign rd_src        = (state_q == ST_SLTWR);
    assign slt_bit       = (state_q == ST_SLTWR) && (counter_q == '0) && slt_q;
    assign alu_cy_in     = (counter_q == '0) ? (alu_op_q[1] | alu_op_q[3]) : cy_q;
    assign done          = done_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_nanov_serial_sequencer.sv
// Scoreboard bench: stimulus queues expected retire/reject events, a monitor checks them.
module tb_nanov_serial_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  counter;
    logic [3:0]  rs1, rs2, rd;
    logic        reg_pause, reg_wr_en, rd_src, slt_bit;
    logic [3:0]  alu_op;
    logic        alu_b_sel_rs2, alu_imm_bit, alu_cy_in, alu_cy_out, alu_lts;
    logic        store_bit_en, done, illegal;

    logic cy_mode  = 1'b0;
    logic cy_const = 1'b0;
    logic lts_val  = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic ill;
        int   at;
        int   wr;
        int   st;
        int   sl;
    } exp_t;
    exp_t q[$];

    int wr_acc = 0, st_acc = 0, sl_acc = 0;

    assign alu_cy_out = cy_mode ? counter[1] : cy_const;
    assign alu_lts    = lts_val;

    nanov_serial_sequencer dut (
        .clk           (clk),
        .rstn          (rstn),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .counter       (counter),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .reg_pause     (reg_pause),
        .reg_wr_en     (reg_wr_en),
        .rd_src        (rd_src),
        .slt_bit       (slt_bit),
        .alu_op        (alu_op),
        .alu_b_sel_rs2 (alu_b_sel_rs2),
        .alu_imm_bit   (alu_imm_bit),
        .alu_cy_in     (alu_cy_in),
        .alu_cy_out    (alu_cy_out),
        .alu_lts       (alu_lts),
        .store_bit_en  (store_bit_en),
        .done          (done),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: accumulate per-instruction activity and compare on every retire/reject.
    always @(negedge clk) begin
        if (!rstn) begin
            wr_acc = 0; st_acc = 0; sl_acc = 0;
        end else begin
            if (done || illegal) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {30'd0, done, illegal}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event_kind", {30'd0, done, illegal}, e.ill ? 32'd1 : 32'd2);
                    chk("event_cycle", cyc, e.at);
                    chk("wr_en_cycles", wr_acc, e.wr);
                    chk("store_cycles", st_acc, e.st);
                    chk("slt_bit_cycles", sl_acc, e.sl);
                end
                wr_acc = 0; st_acc = 0; sl_acc = 0;
            end
            if (reg_wr_en)    wr_acc++;
            if (store_bit_en) st_acc++;
            if (slt_bit)      sl_acc++;
        end
    end

    // Offer one instruction; optionally queue its expected retire/reject event.
    task automatic send(input logic [31:0] ins, input logic ill, input int lat,
                        input int wr, input int st, input int sl, input logic push);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
        if (push) q.push_back('{ill, cyc + lat, wr, st, sl});
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        rstn        = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_pause", {31'd0, reg_pause}, 32'd1);
        chk("rst_counter", {27'd0, counter}, 32'd0);
        chk("rst_outs", {alu_op, reg_wr_en, done, illegal, store_bit_en, alu_cy_in,
                         alu_imm_bit, slt_bit, rd_src}, 32'd0);

        // ADDI x1,x0,5: imm bits 101 then zeros, 32 write cycles.
        send(32'h00500093, 1'b0, 33, 32, 0, 0, 1'b1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("addi_counter", {27'd0, counter}, k);
            chk("addi_imm_bit", {31'd0, alu_imm_bit}, (k == 0 || k == 2) ? 32'd1 : 32'd0);
            chk("addi_pause", {31'd0, reg_pause}, 32'd0);
        end
        @(negedge clk);
        chk("addi_ready_after", {31'd0, instr_ready}, 32'd1);
        chk("addi_rd", {28'd0, rd}, 32'd1);

        // SUB x3,x1,x2: carry-in 1 at bit 0, then previous alu_cy_out.
        cy_mode = 1'b1;
        send(32'h402081B3, 1'b0, 33, 32, 0, 0, 1'b1);
        chk("sub_alu_op", {28'd0, alu_op}, 32'd8);
        chk("sub_b_sel", {31'd0, alu_b_sel_rs2}, 32'd1);
        chk("sub_regs", {20'd0, rs1, rs2, rd}, 32'h123);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk("sub_cy_in", {31'd0, alu_cy_in}, (k == 0) ? 32'd1 : 32'(((k - 1) >> 1) & 1));
        end
        cy_mode = 1'b0;

        // SLT x4,x1,x2 with signed less-than asserted: result 1 in bit 0 only.
        lts_val = 1'b1;
        send(32'h0020A233, 1'b0, 65, 32, 0, 1, 1'b1);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("slt_wr_en", {31'd0, reg_wr_en}, (k >= 32) ? 32'd1 : 32'd0);
            chk("slt_bit", {31'd0, slt_bit}, (k == 32) ? 32'd1 : 32'd0);
            chk("slt_rd_src", {31'd0, rd_src}, (k >= 32) ? 32'd1 : 32'd0);
        end

        // SLTU with carry out high: not less-than, result 0.
        cy_const = 1'b1;
        send(32'h0020B233, 1'b0, 65, 32, 0, 0, 1'b1);
        repeat (66) @(negedge clk);
        cy_const = 1'b0;
        lts_val  = 1'b0;

        // SW x2,0(x1): store capture only.
        send(32'h0020A023, 1'b0, 33, 0, 32, 0, 1'b1);
        repeat (34) @(negedge clk);

        // SLLI is rejected; ADDI x16 is rejected; ADDI x0 never writes.
        send(32'h00109093, 1'b1, 1, 0, 0, 0, 1'b1);
        @(negedge clk);
        chk("slli_illegal", {31'd0, illegal}, 32'd1);
        chk("slli_idle", {31'd0, reg_pause}, 32'd1);
        send(32'h00100813, 1'b1, 1, 0, 0, 0, 1'b1);
        send(32'h00100013, 1'b0, 33, 0, 0, 0, 1'b1);
        repeat (34) @(negedge clk);

        // ADD x5,x1,x2 aborted by reset at bit 12: no event expected.
        send(32'h002082B3, 1'b0, 33, 32, 0, 0, 1'b0);
        repeat (13) @(negedge clk);
        chk("abort_counter", {27'd0, counter}, 32'd12);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_counter0", {27'd0, counter}, 32'd0);
        chk("abort_pause", {31'd0, reg_pause}, 32'd1);
        chk("abort_wr_en", {31'd0, reg_wr_en}, 32'd0);
        chk("abort_ready_in_rst", {31'd0, instr_ready}, 32'd0);
        rstn = 1'b1;
        repeat (40) @(negedge clk);

        // Back-to-back ADDs with valid held: second accepted on first's done cycle.
        base = cyc;
        q.push_back('{1'b0, base + 33, 32, 0, 0});
        q.push_back('{1'b0, base + 66, 32, 0, 0});
        instr_valid = 1'b1;
        instr       = 32'h002082B3;
        repeat (34) @(negedge clk);
        instr_valid = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("pending_events", q.size(), 32'd0);
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
